// File: rtl/d_ff.sv
// WIDTH-bit D register with synchronous active-high reset to RESET_VALUE.
// Define D_FF_CLK_ENABLE_EN to add a load-enable port en after clk.
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             reset,
  input  logic             clk
`ifdef D_FF_CLK_ENABLE_EN
  ,
  input  logic             en
`endif
);

  logic w_load;

`ifdef D_FF_CLK_ENABLE_EN
  assign w_load = en;
`else
  assign w_load = 1'b1;
`endif

  // reset outranks both d and en
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (w_load) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: 1-bit, 8-bit/A5 and a two-stage chain.
// Honours D_FF_CLK_ENABLE_EN when the bundle is built with it.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       d1;
  logic       dc;
  logic [7:0] d8;
  logic       q1;
  logic       qa;
  logic       qb;
  logic [7:0] q8;

  int n_cmp = 0;
  int n_bad = 0;

  logic       m1;
  logic [7:0] m8;
  logic       hq[$];

  always #5 clk = ~clk;

`ifdef D_FF_CLK_ENABLE_EN
  d_ff #(.WIDTH(1)) u_1 (
    .q(q1), .d(d1), .reset(rst), .clk(clk), .en(en));
  d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_8 (
    .q(q8), .d(d8), .reset(rst), .clk(clk), .en(en));
  d_ff u_a (
    .q(qa), .d(dc), .reset(rst), .clk(clk), .en(en));
  d_ff u_b (
    .q(qb), .d(qa), .reset(rst), .clk(clk), .en(en));
`else
  d_ff #(.WIDTH(1)) u_1 (
    .q(q1), .d(d1), .reset(rst), .clk(clk));
  d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_8 (
    .q(q8), .d(d8), .reset(rst), .clk(clk));
  d_ff u_a (
    .q(qa), .d(dc), .reset(rst), .clk(clk));
  d_ff u_b (
    .q(qb), .d(qa), .reset(rst), .clk(clk));
`endif

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each edge either resets, holds (en=0) or captures inputs;
  // the chain is a two-deep history of dc, oldest entry is its output.
  task automatic clk_edge();
    if (rst) begin
      m1 = 1'b0;
      m8 = 8'hA5;
      hq = '{1'b0, 1'b0};
    end else if (en) begin
      m1 = d1;
      m8 = d8;
      hq.push_back(dc);
      void'(hq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    check({tag, "_q1"}, 64'(q1), 64'(m1));
    check({tag, "_q8"}, 64'(q8), 64'(m8));
    check({tag, "_chain"}, 64'(qb), 64'(hq[0]));
  endtask

  initial begin
    hq = '{1'b0, 1'b0};
    en = 1'b1;
    rst = 1'b1;
    d1 = 1'b1;
    dc = 1'b0;
    d8 = 8'h3C;
    #1;

    clk_edge();
    check("rst_e1", 64'(q1), 64'd0);
    check("rst_e1_q8", 64'(q8), 64'hA5);
    clk_edge();
    check("rst_e2", 64'(q1), 64'd0);
    check("rst_e2_q8", 64'(q8), 64'hA5);

    rst = 1'b0;
    d1 = 1'b1;
    clk_edge();
    check("load1", 64'(q1), 64'd1);
    check("w8_load", 64'(q8), 64'h3C);
    d1 = 1'b0;
    clk_edge();
    check("load0", 64'(q1), 64'd0);
    d1 = 1'b1;
    #2;
    check("hold_d", 64'(q1), 64'd0);
    d1 = 1'b0;
    #1;
    d1 = 1'b1;
    clk_edge();
    check("load_tog", 64'(q1), 64'd1);

    rst = 1'b1;
    d1 = 1'b1;
    clk_edge();
    check("prio", 64'(q1), 64'd0);
    rst = 1'b0;
    clk_edge();
    check("recover", 64'(q1), 64'd1);
    rst = 1'b1;
    #2;
    check("mid_rst", 64'(q1), 64'd1);
    clk_edge();
    check("mid_rst_e", 64'(q1), 64'd0);
    clk_edge();

    rst = 1'b0;
    dc = 1'b1;
    clk_edge();
    check("chain_e1", 64'(qb), 64'd0);
    dc = 1'b0;
    clk_edge();
    check("chain_e2", 64'(qb), 64'd1);
    clk_edge();
    check("chain_e3", 64'(qb), 64'd0);

    rst = 1'b1;
    clk_edge();
    check("w8_rst", 64'(q8), 64'hA5);
    rst = 1'b0;
    d8 = 8'h3C;
    clk_edge();
    check("w8_3c", 64'(q8), 64'h3C);

`ifdef D_FF_CLK_ENABLE_EN
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    en = 1'b0;
    d1 = 1'b1;
    clk_edge();
    check("en0_hold", 64'(q1), 64'd0);
    en = 1'b1;
    clk_edge();
    check("en1_load", 64'(q1), 64'd1);
    en = 1'b0;
    rst = 1'b1;
    clk_edge();
    check("en0_rst", 64'(q1), 64'd0);
    check("en0_rst_q8", 64'(q8), 64'hA5);
    en = 1'b1;
    rst = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 7) == 0);
      d1 = 1'($urandom);
      dc = 1'($urandom);
      d8 = 8'($urandom);
`ifdef D_FF_CLK_ENABLE_EN
      en = ($urandom_range(0, 3) != 0);
`endif
      clk_edge();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
